gpu_cmd_queue: RTL and testbench

//  Command scheduler in front of the GPU draw/clear engine. It buffers draw and clear commands from
//  the CPU bus in a FIFO, then issues them one at a time. For each command it holds the ctrl_* fields

---
 rtl/gpu_pkg.sv | 27 ++
 rtl/gpu_cmd_fifo.sv | 48 ++++
 rtl/gpu_cmd_queue.sv | 115 +++++++++++
 tb/tb_gpu_cmd_queue.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gpu_pkg.sv
// gpu_pkg: framebuffer-derived widths, command record and scheduler state encoding.
package gpu_pkg;
    localparam int FB_WIDTH  = 400;
    localparam int FB_HEIGHT = 240;
    localparam int XW = $clog2(FB_WIDTH) + 2;
    localparam int YW = $clog2(FB_HEIGHT) + 2;

    typedef struct packed {
        logic          is_clear;
        logic [31:0]   address;
        logic [15:0]   address_x;
        logic [15:0]   address_y;
        logic [15:0]   image_width;
        logic [XW-1:0] width;
        logic [YW-1:0] height;
        logic [XW-1:0] x;
        logic [YW-1:0] y;
        logic [15:0]   clear_color;
    } gpu_cmd_t;

    typedef enum logic [3:0] {
        IDLE = 4'b0001,
        LOAD = 4'b0010,
        FIRE = 4'b0100,
        WAIT = 4'b1000
    } cmdq_state_e;
endpackage

// File: rtl/gpu_cmd_fifo.sv
// gpu_cmd_fifo: synchronous FIFO of gpu_cmd_t; wrap-bit pointers give full/empty, head is read combinationally.
module gpu_cmd_fifo
    import gpu_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push_i,
    input  gpu_cmd_t                 wdata_i,
    input  logic                     pop_i,
    output gpu_cmd_t                 rdata_o,
    output logic [$clog2(DEPTH):0]   level_o,
    output logic                     full_o,
    output logic                     empty_o
);
    localparam int AW = $clog2(DEPTH);

    gpu_cmd_t      mem_q [DEPTH];
    logic [AW:0]   wr_q, wr_d, rd_q, rd_d;
    logic          do_push, do_pop;

    always_comb begin
        full_o  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
        empty_o = wr_q == rd_q;
        level_o = wr_q - rd_q;
        do_push = push_i && !full_o;
        do_pop  = pop_i && !empty_o;
        wr_d    = wr_q + (AW+1)'(do_push);
        rd_d    = rd_q + (AW+1)'(do_pop);
        rdata_o = mem_q[rd_q[AW-1:0]];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            wr_q <= wr_d;
            rd_q <= rd_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push)
            mem_q[wr_q[AW-1:0]] <= wdata_i;
    end
endmodule

// File: rtl/gpu_cmd_queue.sv
// gpu_cmd_queue: buffers CPU draw/clear commands and issues them one at a time to the GPU engine.
// Optional counters stat_draws/stat_clears/stat_stall are built when GPU_CMDQ_STATS_EN is defined.
module gpu_cmd_queue
    import gpu_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   cmd_valid,
    output logic                   cmd_ready,
    input  logic                   cmd_is_clear,
    input  logic [31:0]            cmd_address,
    input  logic [15:0]            cmd_address_x,
    input  logic [15:0]            cmd_address_y,
    input  logic [15:0]            cmd_image_width,
    input  logic [XW-1:0]          cmd_width,
    input  logic [YW-1:0]          cmd_height,
    input  logic [XW-1:0]          cmd_x,
    input  logic [YW-1:0]          cmd_y,
    input  logic [15:0]            cmd_clear_color,
    output logic [31:0]            ctrl_address,
    output logic [15:0]            ctrl_address_x,
    output logic [15:0]            ctrl_address_y,
    output logic [15:0]            ctrl_image_width,
    output logic [XW-1:0]          ctrl_width,
    output logic [YW-1:0]          ctrl_height,
    output logic [XW-1:0]          ctrl_x,
    output logic [YW-1:0]          ctrl_y,
    output logic [15:0]            ctrl_clear_color,
    output logic                   ctrl_draw,
    output logic                   ctrl_clear,
    input  logic                   gpu_busy,
    output logic [$clog2(DEPTH):0] queue_level,
`ifdef GPU_CMDQ_STATS_EN
    output logic [31:0]            stat_draws,
    output logic [31:0]            stat_clears,
    output logic [31:0]            stat_stall,
`endif
    output logic                   all_done
);
    cmdq_state_e state_q, state_d;
    gpu_cmd_t    ctrl_q, ctrl_d, head, cmd_in;
    logic        full, empty, pop;

    assign cmd_in = {cmd_is_clear, cmd_address, cmd_address_x, cmd_address_y, cmd_image_width,
                     cmd_width, cmd_height, cmd_x, cmd_y, cmd_clear_color};

    gpu_cmd_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push_i  (cmd_valid),
        .wdata_i (cmd_in),
        .pop_i   (pop),
        .rdata_o (head),
        .level_o (queue_level),
        .full_o  (full),
        .empty_o (empty)
    );

    // ctrl_* only load on the pop out of IDLE, so they stay frozen through LOAD/FIRE/WAIT.
    always_comb begin
        state_d = state_q;
        ctrl_d  = ctrl_q;
        pop     = 1'b0;
        case (state_q)
            IDLE: if (!empty && !gpu_busy) begin
                pop     = 1'b1;
                ctrl_d  = head;
                state_d = LOAD;
            end
            LOAD:    state_d = FIRE;
            FIRE:    state_d = WAIT;
            WAIT:    state_d = gpu_busy ? WAIT : IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            ctrl_q  <= '0;
        end else begin
            state_q <= state_d;
            ctrl_q  <= ctrl_d;
        end
    end

    assign {ctrl_address, ctrl_address_x, ctrl_address_y, ctrl_image_width, ctrl_width,
            ctrl_height, ctrl_x, ctrl_y, ctrl_clear_color} = ctrl_q[$bits(gpu_cmd_t)-2:0];
    assign ctrl_draw  = (state_q == FIRE) && !ctrl_q.is_clear;
    assign ctrl_clear = (state_q == FIRE) && ctrl_q.is_clear;
    assign cmd_ready  = !full;
    assign all_done   = empty && (state_q == IDLE) && !gpu_busy;

`ifdef GPU_CMDQ_STATS_EN
    logic [31:0] draws_q, clears_q, stall_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            draws_q  <= '0;
            clears_q <= '0;
            stall_q  <= '0;
        end else begin
            draws_q  <= draws_q + 32'(ctrl_draw);
            clears_q <= clears_q + 32'(ctrl_clear);
            stall_q  <= stall_q + 32'(cmd_valid && !cmd_ready);
        end
    end

    assign stat_draws  = draws_q;
    assign stat_clears = clears_q;
    assign stat_stall  = stall_q;
`endif
endmodule

// File: tb/tb_gpu_cmd_queue.sv
// tb_gpu_cmd_queue: randomized and directed stimulus checked against a queue-based issue model of the scheduler.
module tb_gpu_cmd_queue;
    import gpu_pkg::*;

    localparam int DEPTH = 8;
    localparam int CW = $bits(gpu_cmd_t) - 1;

    logic clk = 1'b0;
    always #10 clk = ~clk;

    logic reset = 1'b1;
    logic cmd_valid = 1'b0;
    logic ext_busy = 1'b0;
    gpu_cmd_t drv = '0;
    int max_work = 3;
    int work = 0;

    logic cmd_ready, ctrl_draw, ctrl_clear, gpu_busy, all_done;
    logic [31:0] ctrl_address;
    logic [15:0] ctrl_address_x, ctrl_address_y, ctrl_image_width, ctrl_clear_color;
    logic [XW-1:0] ctrl_width, ctrl_x;
    logic [YW-1:0] ctrl_height, ctrl_y;
    logic [$clog2(DEPTH):0] queue_level;
`ifdef GPU_CMDQ_STATS_EN
    logic [31:0] stat_draws, stat_clears, stat_stall;
`endif

    gpu_cmd_queue #(.DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_is_clear(drv.is_clear), .cmd_address(drv.address), .cmd_address_x(drv.address_x),
        .cmd_address_y(drv.address_y), .cmd_image_width(drv.image_width), .cmd_width(drv.width),
        .cmd_height(drv.height), .cmd_x(drv.x), .cmd_y(drv.y), .cmd_clear_color(drv.clear_color),
        .ctrl_address(ctrl_address), .ctrl_address_x(ctrl_address_x), .ctrl_address_y(ctrl_address_y),
        .ctrl_image_width(ctrl_image_width), .ctrl_width(ctrl_width), .ctrl_height(ctrl_height),
        .ctrl_x(ctrl_x), .ctrl_y(ctrl_y), .ctrl_clear_color(ctrl_clear_color),
        .ctrl_draw(ctrl_draw), .ctrl_clear(ctrl_clear), .gpu_busy(gpu_busy), .queue_level(queue_level),
`ifdef GPU_CMDQ_STATS_EN
        .stat_draws(stat_draws), .stat_clears(stat_clears), .stat_stall(stat_stall),
`endif
        .all_done(all_done)
    );

    // GPU stand-in: busy rises with the start pulse, then stays up for a random amount of work.
    assign gpu_busy = ext_busy | (work > 0) | ctrl_draw | ctrl_clear;
    always @(posedge clk) begin
        if (reset) work <= 0;
        else if (ctrl_draw || ctrl_clear) work <= int'($urandom_range(0, max_work));
        else if (work > 0) work <= work - 1;
    end

    logic [CW-1:0] dut_ctrl;
    assign dut_ctrl = {ctrl_address, ctrl_address_x, ctrl_address_y, ctrl_image_width, ctrl_width,
                       ctrl_height, ctrl_x, ctrl_y, ctrl_clear_color};

    int errors = 0, checks = 0;

    task automatic check(string name, logic [159:0] act, logic [159:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // Model: pending commands in a queue; an issued command is LOAD one cycle after its pop,
    // pulses the cycle after that, and completes on the first later cycle the GPU is idle.
    gpu_cmd_t mq[$];
    gpu_cmd_t m_ctrl = '0;
    int m_age = -1;
    bit m_valid = 0;
    logic [31:0] m_draws = 0, m_clears = 0, m_stall = 0;

    always @(negedge clk) begin
        bit was_full;
        #2;
        if (m_valid) begin
            check("cmd_ready", 160'(cmd_ready), 160'(mq.size() < DEPTH));
            check("queue_level", 160'(queue_level), 160'(mq.size()));
            check("ctrl_draw", 160'(ctrl_draw), 160'(m_age == 2 && !m_ctrl.is_clear));
            check("ctrl_clear", 160'(ctrl_clear), 160'(m_age == 2 && m_ctrl.is_clear));
            check("ctrl_fields", 160'(dut_ctrl), 160'(m_ctrl[CW-1:0]));
            check("all_done", 160'(all_done), 160'(mq.size() == 0 && m_age < 0 && !gpu_busy));
`ifdef GPU_CMDQ_STATS_EN
            check("stat_draws", 160'(stat_draws), 160'(m_draws));
            check("stat_clears", 160'(stat_clears), 160'(m_clears));
            check("stat_stall", 160'(stat_stall), 160'(m_stall));
`endif
        end
        if (reset) begin
            mq.delete();
            m_ctrl = '0;
            m_age = -1;
            m_valid = 1;
            m_draws = 0;
            m_clears = 0;
            m_stall = 0;
        end else if (m_valid) begin
            was_full = mq.size() >= DEPTH;
            if (cmd_valid && was_full) m_stall++;
            if (m_age == 2) begin
                if (m_ctrl.is_clear) m_clears++;
                else m_draws++;
            end
            if (m_age < 0 && mq.size() > 0 && !gpu_busy) begin
                m_ctrl = mq.pop_front();
                m_age = 1;
            end else if (m_age == 1 || m_age == 2) m_age++;
            else if (m_age == 3 && !gpu_busy) m_age = -1;
            if (cmd_valid && !was_full) mq.push_back(drv);
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic rand_cmd(bit clr);
        drv.is_clear = clr;
        drv.address = $urandom;
        drv.address_x = 16'($urandom);
        drv.address_y = 16'($urandom);
        drv.image_width = 16'($urandom);
        drv.width = XW'($urandom);
        drv.height = YW'($urandom);
        drv.x = XW'($urandom);
        drv.y = YW'($urandom);
        drv.clear_color = 16'($urandom);
    endtask

    task automatic wait_done(string name, int budget);
        int c = 0;
        do begin
            tick();
            #4;
            c++;
        end while (!all_done && c < budget);
        check(name, 160'(all_done), 160'(1));
    endtask

    bit types[8];
    int n, k;
    bit pp, pb, pulse;
    logic [CW-1:0] pc;

    initial begin
        repeat (3) tick();
        #4;
        check("rst_ready", 160'(cmd_ready), 160'(1));
        check("rst_level", 160'(queue_level), 160'(0));
        check("rst_pulses", 160'({ctrl_draw, ctrl_clear}), 160'(0));
        check("rst_ctrl", 160'(dut_ctrl), 160'(0));

        // single draw: pulse three cycles after the push
        tick(); reset = 0; rand_cmd(0);
        drv.x = 10; drv.y = 20; drv.width = 16; drv.height = 16; cmd_valid = 1;
        tick(); cmd_valid = 0; #4;
        check("t1_level", 160'(queue_level), 160'(1));
        tick(); #4;
        check("t1_load_x", 160'(ctrl_x), 160'(10));
        check("t1_load_y", 160'(ctrl_y), 160'(20));
        check("t1_load_wh", 160'({ctrl_width, ctrl_height}), 160'({XW'(16), YW'(16)}));
        check("t1_load_nopulse", 160'(ctrl_draw), 160'(0));
        tick(); #4;
        check("t1_fire", 160'(ctrl_draw), 160'(1));
        tick(); #4;
        check("t1_after_fire", 160'(ctrl_draw), 160'(0));
        wait_done("t1_all_done", 50);

        // fill while the GPU is busy; the ninth push is dropped
        for (int i = 0; i < 8; i++) begin
            tick(); ext_busy = 1; rand_cmd(1'($urandom_range(0, 1)));
            drv.address = 32'(i); types[i] = drv.is_clear; cmd_valid = 1;
        end
        tick(); rand_cmd(0); drv.address = 32'hDEAD; #4;
        check("t2_full_ready", 160'(cmd_ready), 160'(0));
        check("t2_full_level", 160'(queue_level), 160'(8));
        tick(); cmd_valid = 0; #4;
        check("t2_ninth_ignored", 160'(queue_level), 160'(8));
        n = 0;
        for (int c = 0; c < 200 && n < 8; c++) begin
            tick(); ext_busy = 0; #4;
            if (ctrl_draw || ctrl_clear) begin
                check("t2_order", 160'(ctrl_address), 160'(n));
                check("t2_type", 160'(ctrl_clear), 160'(types[n]));
                n++;
            end
        end
        check("t2_pulses", 160'(n), 160'(8));
        wait_done("t2_all_done", 50);

        // alternating clear/draw with random GPU work
        k = 0; n = 0; pp = 0; pb = 0; pc = dut_ctrl;
        for (int c = 0; c < 400 && n < 6; c++) begin
            tick();
            if (k < 6) begin
                rand_cmd(k % 2 == 0);
                if (drv.is_clear) drv.clear_color = 16'hF801;
                cmd_valid = 1;
            end else cmd_valid = 0;
            #4;
            pulse = ctrl_draw | ctrl_clear;
            if (pulse) begin
                n++;
                check("t3_adjacent_pulse", 160'(pp), 160'(0));
            end
            if (ctrl_clear) check("t3_color", 160'(ctrl_clear_color), 160'(16'hF801));
            if (pb) check("t3_hold", 160'(dut_ctrl), 160'(pc));
            if (cmd_valid && cmd_ready) k++;
            pp = pulse; pb = gpu_busy; pc = dut_ctrl;
        end
        check("t3_pulses", 160'(n), 160'(6));
        tick(); cmd_valid = 0;
        wait_done("t3_all_done", 50);

        // full FIFO refills on the pop; the late entry is issued last
        for (int i = 0; i < 8; i++) begin
            tick(); ext_busy = 1; rand_cmd(0); drv.address = 32'(100 + i); cmd_valid = 1;
        end
        n = 0;
        for (int c = 0; c < 300 && n < 9; c++) begin
            tick(); ext_busy = 0;
            if (c < 2) begin rand_cmd(1); drv.address = 32'h4444; cmd_valid = 1; end
            else cmd_valid = 0;
            #4;
            if (c == 1) check("t4_dip", 160'({cmd_ready, queue_level}), 160'({1'b1, 4'd7}));
            if (c == 2) check("t4_refill", 160'(queue_level), 160'(8));
            if (ctrl_draw || ctrl_clear) begin
                check("t4_order", 160'(ctrl_address), 160'(n < 8 ? 100 + n : 32'h4444));
                n++;
            end
        end
        check("t4_pulses", 160'(n), 160'(9));
        wait_done("t4_all_done", 50);

        // reset while a command is in WAIT with three queued
        max_work = 0;
        for (int i = 0; i < 4; i++) begin
            tick(); rand_cmd(0); cmd_valid = 1; #4;
        end
        check("t5_latency", 160'(ctrl_draw), 160'(1));
        tick(); cmd_valid = 0; ext_busy = 1; #4;
        check("t5_queued", 160'(queue_level), 160'(3));
        tick(); reset = 1;
        tick(); reset = 0; ext_busy = 0; #4;
        check("t5_rst_level", 160'(queue_level), 160'(0));
        check("t5_rst_pulses", 160'({ctrl_draw, ctrl_clear}), 160'(0));
        check("t5_rst_ready", 160'(cmd_ready), 160'(1));
        for (int c = 0; c < 10; c++) begin
            tick(); #4;
            check("t5_no_pulse", 160'({ctrl_draw, ctrl_clear}), 160'(0));
        end

`ifdef GPU_CMDQ_STATS_EN
        max_work = 1;
        for (int i = 0; i < 7; i++) begin
            tick(); rand_cmd(i == 2 || i == 5); cmd_valid = 1;
        end
        tick(); cmd_valid = 0;
        wait_done("t6_drain", 100);
        check("t6_draws", 160'(stat_draws), 160'(5));
        check("t6_clears", 160'(stat_clears), 160'(2));
        for (int i = 0; i < 12; i++) begin
            tick(); ext_busy = 1; rand_cmd(0); cmd_valid = 1;
        end
        tick(); cmd_valid = 0; #4;
        check("t6_stall", 160'(stat_stall), 160'(4));
`endif

        tick(); reset = 1; ext_busy = 0; cmd_valid = 0;
        tick(); reset = 0;
        for (int c = 0; c < 3000; c++) begin
            tick();
            rand_cmd(1'($urandom_range(0, 1)));
            cmd_valid = $urandom_range(0, 2) != 0;
            ext_busy = $urandom_range(0, 9) == 0;
            max_work = int'($urandom_range(0, 6));
            reset = $urandom_range(0, 599) == 0;
        end
        tick(); reset = 0; cmd_valid = 0; ext_busy = 0;
        wait_done("final_drain", 200);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
